ethernet_header_extract: RTL

Stream-side front end for `ethernet_filter`. It sits on an AXI-Stream frame path and captures the first 14 bytes of each frame into a 112-bit `ethernet_header` vector, in the layout `ethernet_filter` consumes. It forwards the frame unchanged through a one-stage register and counts frames and runts. `header_valid` pulses on the cycle the header-completing beat appears on the output, so the filter decision can be aligned with the data.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/axis_pipe_reg.sv | 56 +++++
 rtl/ethernet_header_extract.sv | 133 +++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet header definitions: header byte count, packed header layout
// and the extractor state encoding.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;

  // Packed MSB-first, so dst_mac lands in [47:0] and ethertype in [111:96].
  typedef struct packed {
    logic [15:0] ethertype;
    logic [47:0] src_mac;
    logic [47:0] dst_mac;
  } eth_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } ehx_state_t;

  function automatic int hdr_beats(input int keep_width);
    return (ETH_HDR_BYTES + keep_width - 1) / keep_width;
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage AXI-Stream register; payload is held stable while stalled.
module axis_pipe_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] tdata_p1;
  logic [KEEP_WIDTH-1:0] tkeep_p1;
  logic                  tlast_p1;
  logic [USER_WIDTH-1:0] tuser_p1;

  assign s_axis_tready = m_axis_tready || !vld_p1;

  // Stage p1: output register, loaded only when the slot is free or draining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
      tuser_p1 <= '0;
    end else if (s_axis_tvalid && s_axis_tready) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= s_axis_tdata;
      tkeep_p1 <= s_axis_tkeep;
      tlast_p1 <= s_axis_tlast;
      tuser_p1 <= s_axis_tuser;
    end else if (m_axis_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = tdata_p1;
  assign m_axis_tkeep  = tkeep_p1;
  assign m_axis_tlast  = tlast_p1;
  assign m_axis_tuser  = tuser_p1;

endmodule

// File: rtl/ethernet_header_extract.sv
// Captures the 14-byte Ethernet header of each frame while forwarding the
// stream through one register stage; flags complete headers and runts.
module ethernet_header_extract #(
  parameter int DATA_WIDTH            = 64,
  parameter int KEEP_WIDTH            = DATA_WIDTH / 8,
  parameter int USER_WIDTH            = 1,
  parameter int ETHERNET_HEADER_WIDTH = 112
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [ETHERNET_HEADER_WIDTH-1:0] ethernet_header,
  output logic                             header_valid,
  output logic                             header_error,
  output logic [31:0]                      frame_count,
  output logic [31:0]                      runt_count
);
  import eth_pkg::*;

  localparam int HDR_BEATS = hdr_beats(KEEP_WIDTH);
  localparam int EXT_BYTES = KEEP_WIDTH + ETH_HDR_BYTES;

  ehx_state_t state, state_next;
  eth_hdr_t   hdr_q;
  logic       accept;
  logic       hdr_done;
  logic       hv_next;
  logic       he_next;

  logic [EXT_BYTES-1:0]         keep_ext, keep_sh;
  logic [EXT_BYTES*8-1:0]       data_ext, data_sh;
  logic [ETH_HDR_BYTES-1:0]     keep_al;
  logic [ETH_HDR_BYTES*8-1:0]   data_al;
  logic [KEEP_WIDTH*9-1:0]      unused_sh;

  axis_pipe_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_pipe (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

  assign accept = s_axis_tvalid && s_axis_tready;

  // Map input lanes onto frame-byte positions: the second header beat carries
  // bytes KEEP_WIDTH.., so it is shifted up by one beat width.
  assign keep_ext  = {{ETH_HDR_BYTES{1'b0}}, s_axis_tkeep};
  assign data_ext  = {{(ETH_HDR_BYTES * 8){1'b0}}, s_axis_tdata};
  assign keep_sh   = (state == HDR) ? (keep_ext << KEEP_WIDTH) : keep_ext;
  assign data_sh   = (state == HDR) ? (data_ext << (8 * KEEP_WIDTH)) : data_ext;
  assign keep_al   = keep_sh[ETH_HDR_BYTES-1:0];
  assign data_al   = data_sh[ETH_HDR_BYTES*8-1:0];
  assign unused_sh = {keep_sh[EXT_BYTES-1:ETH_HDR_BYTES], data_sh[EXT_BYTES*8-1:ETH_HDR_BYTES*8]};

  // tkeep is contiguous, so the header is complete iff frame byte 13 is valid.
  assign hdr_done = keep_al[ETH_HDR_BYTES-1];

  always_comb begin
    state_next = state;
    hv_next    = 1'b0;
    he_next    = 1'b0;
    if (accept) begin
      case (state)
        IDLE, HDR: begin
          if (hdr_done) begin
            hv_next    = 1'b1;
            state_next = s_axis_tlast ? IDLE : PAYLOAD;
          end else if (s_axis_tlast) begin
            he_next    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = (HDR_BEATS > 1) ? HDR : IDLE;
          end
        end
        PAYLOAD: begin
          if (s_axis_tlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Stage p1: state, header bytes, pulses and counters update with the beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hdr_q        <= '0;
      header_valid <= 1'b0;
      header_error <= 1'b0;
      frame_count  <= '0;
      runt_count   <= '0;
    end else begin
      state        <= state_next;
      header_valid <= hv_next;
      header_error <= he_next;
      if (hv_next) frame_count <= frame_count + 32'd1;
      if (he_next) runt_count  <= runt_count + 32'd1;
      if (accept && (state != PAYLOAD)) begin
        for (int i = 0; i < ETH_HDR_BYTES; i++) begin
          if (keep_al[i]) hdr_q[8*i +: 8] <= data_al[8*i +: 8];
        end
      end
    end
  end

  assign ethernet_header = hdr_q;

endmodule
